// File: rtl/param_serial_add_sub.sv
// Multi-cycle adder/subtractor processing CHUNK bits per clock, with valid/ready on both sides.
// Optional build macro ADD_SUB_SATURATE_EN adds a sat_o output and clamps sum_o on signed overflow.
module param_serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             cin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
`ifdef ADD_SUB_SATURATE_EN
    output logic             sat_o,
`endif
    output logic [1:0]       dbg_state_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Handshake: an operand transfers on a rising edge with valid_i && ready_o (IDLE only);
    // a result transfers on a rising edge with valid_o && ready_i (DONE only).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_sub;
    logic [KW-1:0]    r_k;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;
    logic             w_accept;
    logic             w_ovf;
    logic             w_cout;

    assign w_accept = (r_state == S_IDLE) && valid_i;
    assign w_last   = (r_k == KW'(NCHUNK - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (valid_i) w_next = S_CALC;
            S_CALC:  if (w_last)  w_next = S_DONE;
            S_DONE:  if (ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_k == KW'(i)) begin
                w_a_chunk = r_a[i*CHUNK +: CHUNK];
                w_b_chunk = r_b[i*CHUNK +: CHUNK];
            end
        end
    end

    assign w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < NCHUNK; i++) begin
            if (r_k == KW'(i)) begin
                w_acc_next[i*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
            end
        end
    end

    // r_b already holds ~B for subtraction, so the usual same-sign overflow rule applies directly.
    assign w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
    assign w_cout = r_sub ? ~w_chunk_sum[CHUNK] : w_chunk_sum[CHUNK];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_k     <= '0;
            sum_o   <= '0;
            cout_o  <= 1'b0;
            ovf_o   <= 1'b0;
`ifdef ADD_SUB_SATURATE_EN
            sat_o   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a_i;
            r_b     <= sub_i ? ~b_i : b_i;
            r_carry <= sub_i ? ~cin_i : cin_i;
            r_sub   <= sub_i;
            r_k     <= '0;
        end else if (r_state == S_CALC) begin
            r_acc   <= w_acc_next;
            r_carry <= w_chunk_sum[CHUNK];
            if (w_last) begin
                r_k    <= '0;
                cout_o <= w_cout;
                ovf_o  <= w_ovf;
`ifdef ADD_SUB_SATURATE_EN
                sat_o  <= w_ovf;
                if (w_ovf) begin
                    // Raw MSB set means the true result overflowed upwards.
                    sum_o <= w_acc_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                 : {1'b1, {(WIDTH-1){1'b0}}};
                end else begin
                    sum_o <= w_acc_next;
                end
`else
                sum_o  <= w_acc_next;
`endif
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign ready_o     = (r_state == S_IDLE);
    assign valid_o     = (r_state == S_DONE);
    assign dbg_state_o = r_state;

endmodule
